// File: rtl/clk_ctrl_pkg.sv
// Shared constants for the clock-enable controller: mode encoding,
// control FSM states and default parameter values.
package clk_ctrl_pkg;

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_HALT = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT      = 2'd1,
    ST_STEP_IDLE = 2'd2,
    ST_STEP_FIRE = 2'd3
  } ctrl_state_e;

  localparam int DEF_NUM_CH  = 2;
  localparam int DEF_DIV_W   = 16;
  localparam int DEF_RST_DIV = 0;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One clock-enable channel: free-running counter against a divide
// register, terminal-count detect and a registered one-cycle ce strobe.
module clk_div_ch
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             fire,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             ce,
  output logic             tc
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] div;

  assign tc = (count == div);

  // Count in RUN, clear on a step, hold otherwise; a divide loaded while
  // halted that is smaller than the held count restarts the count at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      div   <= DIV_W'(RST_DIV);
      ce    <= 1'b0;
    end else begin
      ce <= 1'b0;
      if (fire) begin
        count <= '0;
        ce    <= 1'b1;
      end else if (run) begin
        if (tc) begin
          count <= '0;
          ce    <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end else if (load && (count > load_div)) begin
        count <= '0;
      end
      if (load) begin
        div <= load_div;
      end
    end
  end

endmodule

// File: rtl/clk_ctrl.sv
// Clock-enable controller: RUN/HALT/STEP control FSM, step edge detect
// and a single-slot divide-update handshake feeding NUM_CH channels.
module clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int RST_DIV = DEF_RST_DIV
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        step_req,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]            cfg_div,
  output logic [NUM_CH-1:0]           ce,
  output logic                        running
);

  localparam int CH_W = ch_width(NUM_CH);

  ctrl_state_e       state;
  ctrl_state_e       state_next;
  logic              step_q;
  logic              step_rise;
  logic              run_en;
  logic              fire_en;
  logic              ready_en;
  logic              pend_valid;
  logic [CH_W-1:0]   pend_ch;
  logic [DIV_W-1:0]  pend_div;
  logic              pend_hit;
  logic              pend_discard;
  logic              pend_apply;
  logic [NUM_CH-1:0] tc;
  logic [NUM_CH-1:0] load;

  assign step_rise = step_req & ~step_q;

  // State register, with running tracking the state it is entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_HALT;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == ST_RUN);
    end
  end

  // Mode is followed every cycle; only an armed step state can fire.
  always_comb begin
    state_next = ST_HALT;
    case (mode)
      MODE_RUN:  state_next = ST_RUN;
      MODE_STEP: state_next = (state == ST_STEP_IDLE && step_rise) ? ST_STEP_FIRE
                                                                   : ST_STEP_IDLE;
      default:   state_next = ST_HALT;
    endcase
  end

  // Decode state into the channel controls.
  always_comb begin
    run_en  = (state == ST_RUN);
    fire_en = (state == ST_STEP_FIRE);
  end

  // Remember the previous step level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_req;
    end
  end

  // Route the pending update to its channel: at terminal count while
  // running so no period is cut short, immediately otherwise.
  always_comb begin
    load     = '0;
    pend_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend_ch == CH_W'(i)) begin
        pend_hit = 1'b1;
        load[i]  = pend_valid && (!run_en || tc[i]);
      end
    end
  end

  assign pend_discard = pend_valid & ~pend_hit;
  assign pend_apply   = (|load) | pend_discard;
  assign cfg_ready    = ready_en & ~pend_valid;

  // Single pending slot; ready_en keeps cfg_ready low until the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en   <= 1'b0;
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (cfg_valid && cfg_ready) begin
        pend_valid <= 1'b1;
        pend_ch    <= cfg_ch;
        pend_div   <= cfg_div;
      end else if (pend_apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .DIV_W  (DIV_W),
      .RST_DIV(RST_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run_en),
      .fire    (fire_en),
      .load    (load[g]),
      .load_div(pend_div),
      .ce      (ce[g]),
      .tc      (tc[g])
    );
  end

endmodule

// File: tb/tb_clk_ctrl.sv
// Self-checking bench for clk_ctrl with three channels, so that a
// channel select of 3 exercises the discarded-update path.
module tb_clk_ctrl;

  localparam int NCH  = 3;
  localparam int DW   = 8;
  localparam int RDIV = 0;
  localparam int CW   = 2;

  localparam int MS_HALT  = 0;
  localparam int MS_RUN   = 1;
  localparam int MS_ARMED = 2;
  localparam int MS_FIRE  = 3;

  logic           clk;
  logic           rst_n;
  logic [1:0]     mode;
  logic           step_req;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic [NCH-1:0] ce;
  logic           running;

  int total;
  int bad;

  // Reference model state, stepped once per rising edge.
  int             m_st;
  int             m_cnt [NCH];
  int             m_div [NCH];
  bit             m_pend;
  int             m_pch;
  int             m_pdiv;
  bit             m_rdy_en;
  bit             m_prev_step;
  logic [NCH-1:0] m_ce;
  bit             m_run;

  clk_ctrl #(
    .NUM_CH (NCH),
    .DIV_W  (DW),
    .RST_DIV(RDIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .step_req (step_req),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .ce       (ce),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NCH+1:0] expect_vec();
    return {m_ce, (m_rdy_en && !m_pend), m_run};
  endfunction

  task automatic model_reset();
    m_st        = MS_HALT;
    m_pend      = 1'b0;
    m_pch       = 0;
    m_pdiv      = 0;
    m_rdy_en    = 1'b0;
    m_prev_step = 1'b0;
    m_ce        = '0;
    m_run       = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_div[i] = RDIV;
    end
  endtask

  task automatic model_edge();
    bit             rise;
    bit             acc;
    bit             applied;
    bit             here;
    int             nst;
    logic [NCH-1:0] nce;
    rise    = step_req && !m_prev_step;
    acc     = cfg_valid && m_rdy_en && !m_pend;
    applied = 1'b0;
    nce     = '0;
    for (int i = 0; i < NCH; i++) begin
      here = m_pend && (m_pch == i) && (m_st != MS_RUN || m_cnt[i] == m_div[i]);
      if (m_st == MS_FIRE) begin
        nce[i]   = 1'b1;
        m_cnt[i] = 0;
      end else if (m_st == MS_RUN) begin
        if (m_cnt[i] == m_div[i]) begin
          nce[i]   = 1'b1;
          m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end else if (here && m_cnt[i] > m_pdiv) begin
        m_cnt[i] = 0;
      end
      if (here) begin
        m_div[i] = m_pdiv;
        applied  = 1'b1;
      end
    end
    if (m_pend && m_pch >= NCH) applied = 1'b1;
    if (acc) begin
      m_pend = 1'b1;
      m_pch  = int'(cfg_ch);
      m_pdiv = int'(cfg_div);
    end else if (applied) begin
      m_pend = 1'b0;
    end
    case (mode)
      2'd0:    nst = MS_RUN;
      2'd2:    nst = (m_st == MS_ARMED && rise) ? MS_FIRE : MS_ARMED;
      default: nst = MS_HALT;
    endcase
    m_st        = nst;
    m_run       = (nst == MS_RUN);
    m_rdy_en    = 1'b1;
    m_prev_step = step_req;
    m_ce        = nce;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_cfg(input int ch, input int dv);
    int n;
    n         = 0;
    cfg_ch    = CW'(ch);
    cfg_div   = DW'(dv);
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("[TB] FAIL cfg_wait got=ready_low_%0d_cycles want=ready_high", n);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    mode      = 2'd0;
    step_req  = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    rst_n     = 1'b0;
    model_reset();
    #2;
    total++;
    if ({ce, cfg_ready, running} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%b want=%b", {ce, cfg_ready, running}, 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if ({ce, cfg_ready, running} !== 5'b000_1_1) begin
      bad++;
      $display("[TB] FAIL first_clock got=%b want=%b", {ce, cfg_ready, running}, 5'b000_1_1);
    end
    tick();
    total++;
    if (ce !== 3'b111) begin
      bad++;
      $display("[TB] FAIL second_clock_ce got=%b want=%b", ce, 3'b111);
    end
    repeat (5) begin
      tick();
      total++;
      if ({ce, cfg_ready, running} !== expect_vec()) begin
        bad++;
        $display("[TB] FAIL reset_run got=%b want=%b", {ce, cfg_ready, running}, expect_vec());
      end
    end
  endtask

  task automatic test_cfg_midcount();
    int n;
    int low;
    int last0;
    int last1;
    mode = 2'd1;
    tick();
    tick();
    send_cfg(0, 5);
    send_cfg(1, 2);
    n = 0;
    while (m_pend && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL halt_apply_ready got=%b want=1", cfg_ready);
    end
    mode = 2'd0;
    n    = 0;
    do begin
      tick();
      total++;
      if ({ce, cfg_ready, running} !== expect_vec()) begin
        bad++;
        $display("[TB] FAIL midcount_wait got=%b want=%b", {ce, cfg_ready, running}, expect_vec());
      end
      n++;
    end while (m_cnt[0] != 1 && n < 50);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd3;
    tick();
    cfg_valid = 1'b0;
    low       = (cfg_ready === 1'b0) ? 1 : 0;
    n         = 0;
    while (m_pend && n < 20) begin
      tick();
      total++;
      if ({ce, cfg_ready, running} !== expect_vec()) begin
        bad++;
        $display("[TB] FAIL midcount_pend got=%b want=%b", {ce, cfg_ready, running}, expect_vec());
      end
      if (cfg_ready === 1'b0) low++;
      n++;
    end
    total++;
    if (low != 4) begin
      bad++;
      $display("[TB] FAIL midcount_ready_low got=%0d want=4", low);
    end
    last0 = -1;
    last1 = -1;
    for (int t = 0; t < 24; t++) begin
      tick();
      total++;
      if ({ce, cfg_ready, running} !== expect_vec()) begin
        bad++;
        $display("[TB] FAIL midcount_run got=%b want=%b", {ce, cfg_ready, running}, expect_vec());
      end
      if (ce[0] === 1'b1) begin
        if (last0 >= 0) begin
          total++;
          if (t - last0 != 4) begin
            bad++;
            $display("[TB] FAIL ch0_period got=%0d want=4", t - last0);
          end
        end
        last0 = t;
      end
      if (ce[1] === 1'b1) begin
        if (last1 >= 0) begin
          total++;
          if (t - last1 != 3) begin
            bad++;
            $display("[TB] FAIL ch1_period got=%0d want=3", t - last1);
          end
        end
        last1 = t;
      end
    end
  endtask

  task automatic test_halt();
    int n;
    send_cfg(0, 4);
    n = 0;
    while ((m_pend || m_cnt[0] != 1) && n < 50) begin
      tick();
      n++;
    end
    mode = 2'd1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
      if ({ce, cfg_ready, running} !== expect_vec()) begin
        bad++;
        $display("[TB] FAIL halt_model got=%b want=%b", {ce, cfg_ready, running}, expect_vec());
      end
      if (i >= 2) begin
        total++;
        if (ce !== '0) begin
          bad++;
          $display("[TB] FAIL halt_ce got=%b want=000", ce);
        end
      end
    end
    mode = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (ce[0] !== (i == 4) || running !== 1'b1) begin
        bad++;
        $display("[TB] FAIL resume_ce0 tick=%0d got=%b/%b want=%b/1", i, ce[0], running, (i == 4));
      end
    end
  endtask

  task automatic test_step();
    int pulses;
    int stray;
    mode     = 2'd2;
    step_req = 1'b0;
    repeat (3) tick();
    for (int burst = 0; burst < 2; burst++) begin
      pulses   = 0;
      stray    = 0;
      step_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        total++;
        if ({ce, cfg_ready, running} !== expect_vec()) begin
          bad++;
          $display("[TB] FAIL step_model got=%b want=%b", {ce, cfg_ready, running}, expect_vec());
        end
        if (ce === 3'b111) pulses++;
        else if (ce !== 3'b000) stray++;
      end
      total++;
      if (pulses != 1 || stray != 0) begin
        bad++;
        $display("[TB] FAIL step_pulse burst=%0d got=%0d/%0d want=1/0", burst, pulses, stray);
      end
      step_req = 1'b0;
      repeat (3) tick();
    end
    mode = 2'd1;
    repeat (2) tick();
    step_req = 1'b1;
    repeat (2) tick();
    mode   = 2'd2;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ce !== 3'b000) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("[TB] FAIL step_edge_ignored got=%0d want=0", pulses);
    end
    step_req = 1'b0;
    mode     = 2'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if ({ce, cfg_ready, running} !== expect_vec()) begin
        bad++;
        $display("[TB] FAIL post_step_run got=%b want=%b", {ce, cfg_ready, running}, expect_vec());
      end
    end
  endtask

  task automatic test_discard();
    int n;
    mode = 2'd0;
    n    = 0;
    while (m_pend && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL discard_pre_ready got=%b want=1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_ch    = 2'd3;
    cfg_div   = 8'd1;
    tick();
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL discard_busy got=%b want=0", cfg_ready);
    end
    tick();
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL discard_ready_back got=%b want=1", cfg_ready);
    end
    repeat (20) begin
      tick();
      total++;
      if ({ce, cfg_ready, running} !== expect_vec()) begin
        bad++;
        $display("[TB] FAIL discard_run got=%b want=%b", {ce, cfg_ready, running}, expect_vec());
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6)      mode = 2'd0;
        else if (r < 7) mode = 2'd1;
        else if (r < 9) mode = 2'd2;
        else            mode = 2'd3;
      end
      if ($urandom_range(0, 3) == 0) step_req = ~step_req;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_ch    = CW'($urandom_range(0, 3));
      cfg_div   = DW'($urandom_range(0, 6));
      tick();
      total++;
      if ({ce, cfg_ready, running} !== expect_vec()) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got=%b want=%b", i, {ce, cfg_ready, running}, expect_vec());
      end
    end
    cfg_valid = 1'b0;
    step_req  = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 2'd2;
    n    = 0;
    repeat (3) tick();
    while ((m_pend || cfg_ready !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    step_req  = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd5;
    tick();
    cfg_valid = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #1;
    total++;
    if ({ce, cfg_ready, running} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_in_fire got=%b want=%b", {ce, cfg_ready, running}, 5'b0);
    end
    @(negedge clk);
    @(negedge clk);
    mode     = 2'd1;
    step_req = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (ce !== 3'b000) begin
        bad++;
        $display("[TB] FAIL no_pulse_after_reset got=%b want=000", ce);
      end
    end
    mode = 2'd0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++;
      if (ce !== ((i == 1) ? 3'b000 : 3'b111)) begin
        bad++;
        $display("[TB] FAIL reset_div_restored tick=%0d got=%b want=%b", i, ce, (i == 1) ? 3'b000 : 3'b111);
      end
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (ce !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_async_ce got=%b want=000", ce);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_cfg_midcount();
    test_halt();
    test_step();
    test_discard();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
